// File: rtl/rv_sync_fifo.sv
// rv_sync_fifo: single-clock first-word-fall-through ready/valid FIFO built from explicit register cells.
// Define RV_SYNC_FIFO_COUNT_EN to add the count and almost_full outputs.

module rv_sync_fifo #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 8,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  input  logic [WIDTH-1:0] enq_data,
  output logic             enq_ready,
  output logic             deq_valid,
  output logic [WIDTH-1:0] deq_data,
  input  logic             deq_ready
`ifdef RV_SYNC_FIFO_COUNT_EN
  ,
  output logic [AWIDTH:0]  count,
  output logic             almost_full
`endif
);

  logic [AWIDTH:0]   wr_ptr;
  logic [AWIDTH:0]   rd_ptr;
  logic [AWIDTH:0]   wr_ptr_next;
  logic [AWIDTH:0]   rd_ptr_next;
  logic [AWIDTH-1:0] wr_idx;
  logic [AWIDTH-1:0] rd_idx;
  logic              full;
  logic              empty;
  logic              enq_fire;
  logic              deq_fire;
  logic [WIDTH-1:0]  mem [DEPTH];

  assign wr_idx = wr_ptr[AWIDTH-1:0];
  assign rd_idx = rd_ptr[AWIDTH-1:0];

  // Flags depend only on registered pointers, never on the handshake inputs.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_idx == rd_idx) && (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]);

  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign deq_data  = mem[rd_idx];

  assign enq_fire = enq_valid && enq_ready;
  assign deq_fire = deq_valid && deq_ready;

  assign wr_ptr_next = wr_ptr + (AWIDTH+1)'(1);
  assign rd_ptr_next = rd_ptr + (AWIDTH+1)'(1);

  REGISTER_R_CE #(.N(AWIDTH+1)) wr_ptr_cell (
    .clk (clk),
    .rst (rst),
    .ce  (enq_fire),
    .d   (wr_ptr_next),
    .q   (wr_ptr)
  );

  REGISTER_R_CE #(.N(AWIDTH+1)) rd_ptr_cell (
    .clk (clk),
    .rst (rst),
    .ce  (deq_fire),
    .d   (rd_ptr_next),
    .q   (rd_ptr)
  );

  // One enable-only cell per entry; contents survive reset and are don't-care afterwards.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      logic entry_we;
      assign entry_we = enq_fire && (wr_idx == AWIDTH'(gi));

      REGISTER_CE #(.N(WIDTH)) entry_cell (
        .clk (clk),
        .ce  (entry_we),
        .d   (enq_data),
        .q   (mem[gi])
      );
    end
  endgenerate

`ifdef RV_SYNC_FIFO_COUNT_EN
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= (AWIDTH+1)'(DEPTH-1));
`endif

endmodule

// Register with synchronous active-high reset to INIT and clock enable.
module REGISTER_R_CE #(
  parameter int           N    = 1,
  parameter logic [N-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= INIT;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

// Register with clock enable and no reset.
module REGISTER_CE #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         ce,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (ce) begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_rv_sync_fifo.sv
// Directed scoreboard bench for rv_sync_fifo (WIDTH=32, DEPTH=8); set RV_SYNC_FIFO_COUNT_EN to also check count/almost_full.

module tb_rv_sync_fifo;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 8;
  localparam int AWIDTH = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             enq_valid;
  logic [WIDTH-1:0] enq_data;
  logic             enq_ready;
  logic             deq_valid;
  logic [WIDTH-1:0] deq_data;
  logic             deq_ready;
`ifdef RV_SYNC_FIFO_COUNT_EN
  logic [AWIDTH:0]  count;
  logic             almost_full;
`endif

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] sb[$];
  int unsigned      pval;

  always #5 clk = ~clk;

  rv_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .enq_valid   (enq_valid),
    .enq_data    (enq_data),
    .enq_ready   (enq_ready),
    .deq_valid   (deq_valid),
    .deq_data    (deq_data),
    .deq_ready   (deq_ready)
`ifdef RV_SYNC_FIFO_COUNT_EN
    ,
    .count       (count),
    .almost_full (almost_full)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, update the scoreboard at the edge, then check outputs on the negedge.
  task automatic step(input logic r, input logic ev, input logic [31:0] ed, input logic dr, output logic accepted);
    int occ;
    rst       = r;
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    @(posedge clk);
    occ      = sb.size();
    accepted = 1'b0;
    if (r) begin
      sb.delete();
    end else begin
      if (dr && occ > 0) begin
        void'(sb.pop_front());
      end
      if (ev && occ < DEPTH) begin
        sb.push_back(ed);
        accepted = 1'b1;
      end
    end
    @(negedge clk);
    chk("enq_ready", {31'b0, enq_ready}, {31'b0, sb.size() < DEPTH});
    chk("deq_valid", {31'b0, deq_valid}, {31'b0, sb.size() > 0});
    if (sb.size() > 0) begin
      chk("deq_data", deq_data, sb[0]);
    end
`ifdef RV_SYNC_FIFO_COUNT_EN
    chk("count", 32'(count), 32'(sb.size()));
    chk("almost_full", {31'b0, almost_full}, {31'b0, sb.size() >= DEPTH-1});
`endif
    $display("[TB] t=%0t rst=%0b enq=%0b/%h deq_rdy=%0b -> occ=%0d deq_valid=%0b deq_data=%h",
             $time, r, ev, ed, dr, sb.size(), deq_valid, deq_data);
  endtask

  initial begin
    logic acc;
    rst       = 1'b1;
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;

    // Reset then idle
    step(1'b1, 1'b0, 32'h0, 1'b0, acc);
    step(1'b1, 1'b1, 32'h1234, 1'b1, acc);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0, acc);

    // Single word, held, then consumed
    step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, acc);
    step(1'b0, 1'b0, 32'h0, 1'b0, acc);
    step(1'b0, 1'b0, 32'h0, 1'b0, acc);
    step(1'b0, 1'b0, 32'h0, 1'b1, acc);
    step(1'b0, 1'b0, 32'h0, 1'b1, acc);

    // Fill to full, then a 9th word must be refused
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'(i), 1'b0, acc);
    step(1'b0, 1'b1, 32'h8, 1'b0, acc);
    chk("full_refuses_8", {31'b0, acc}, 32'h0);
    step(1'b0, 1'b1, 32'h8, 1'b0, acc);
    chk("full_refuses_8_again", {31'b0, acc}, 32'h0);

    // Drain from full with producer holding valid; 0x8 goes in one cycle after the first deq
    pval = 8;
    step(1'b0, 1'b1, 32'(pval), 1'b1, acc);
    chk("no_accept_on_first_deq", {31'b0, acc}, 32'h0);
    step(1'b0, 1'b1, 32'(pval), 1'b1, acc);
    chk("accept_8_after_deq", {31'b0, acc}, 32'h1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1, acc);

    // Streaming 40 words with both sides always ready
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 32'(i), 1'b1, acc);
      chk("stream_accept", {31'b0, acc}, 32'h1);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, acc);
    step(1'b0, 1'b0, 32'h0, 1'b1, acc);

    // Mid-stream reset discards contents and the word offered during reset
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0, acc);
    step(1'b1, 1'b1, 32'hFF, 1'b0, acc);
    chk("reset_discards_enq", {31'b0, (sb.size() == 0)}, 32'h1);
    step(1'b0, 1'b1, 32'hA5, 1'b0, acc);
    step(1'b0, 1'b0, 32'h0, 1'b1, acc);
    step(1'b0, 1'b0, 32'h0, 1'b1, acc);

    // Underflow attempt while empty has no effect
    step(1'b0, 1'b0, 32'h0, 1'b1, acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: observed no completion, expected finish before 200000");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
